// File: rtl/mchan_pkg.sv
// ----------------------------------------------------------------------------
// mchan_pkg
// Shared defaults and types for the MCHAN synchronisation table.
//   MCHAN_CMD_WIDTH_DEF : default width of the per-transfer command count
//   mchan_synch_err_e   : classification of a per-source error in one cycle
//   sid_width()         : SID field width for a given number of transfer IDs
// ----------------------------------------------------------------------------
package mchan_pkg;

   localparam int MCHAN_CMD_WIDTH_DEF = 10;

   typedef enum logic [1:0] {
      NONE      = 2'd0,
      BAD_SID   = 2'd1,
      UNDERFLOW = 2'd2,
      OVERFLOW  = 2'd3
   } mchan_synch_err_e;

   // $clog2 of 1 is 0; a SID field always needs at least one bit.
   function automatic int sid_width(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/mchan_synch_cnt.sv
// ----------------------------------------------------------------------------
// mchan_synch_cnt
// Saturating command counter: two add inputs and two single-step decrements
// all combine in one cycle; the result clamps to [0, 2^CNT_WIDTH-1].
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   add_a_i, add_b_i      : amounts to add this cycle (0 when idle)
//   dec_a_i, dec_b_i      : decrement by one each
//   cnt_o                 : registered count
//   cnt_next_o            : count that will be loaded on the next edge
//   underflow_o           : this cycle's result went below zero (clamped)
//   overflow_o            : this cycle's result exceeded the maximum (clamped)
// ----------------------------------------------------------------------------
module mchan_synch_cnt
   import mchan_pkg::*;
#(
   parameter int MCHAN_CMD_WIDTH = MCHAN_CMD_WIDTH_DEF,
   parameter int CNT_WIDTH       = MCHAN_CMD_WIDTH + 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [MCHAN_CMD_WIDTH-1:0] add_a_i,
   input  logic [MCHAN_CMD_WIDTH-1:0] add_b_i,
   input  logic                       dec_a_i,
   input  logic                       dec_b_i,
   output logic [CNT_WIDTH-1:0]       cnt_o,
   output logic [CNT_WIDTH-1:0]       cnt_next_o,
   output logic                       underflow_o,
   output logic                       overflow_o
);

   // Signed working width. Two headroom bits cover the default sizing; the
   // third keeps cur + 2*max_add from wrapping when CNT_WIDTH == MCHAN_CMD_WIDTH.
   localparam int SUM_W = CNT_WIDTH + 3;
   localparam logic signed [SUM_W-1:0] CNT_MAX = {3'b000, {CNT_WIDTH{1'b1}}};

   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [CNT_WIDTH-1:0]    cnt_d;
   logic signed [SUM_W-1:0] sum_s;

   always_comb begin
      sum_s = $signed(SUM_W'(cnt_q))
            + $signed(SUM_W'(add_a_i))
            + $signed(SUM_W'(add_b_i))
            - $signed(SUM_W'(dec_a_i))
            - $signed(SUM_W'(dec_b_i));
      underflow_o = (sum_s < 0);
      overflow_o  = (sum_s > CNT_MAX);
      if (underflow_o) begin
         cnt_d = '0;
      end else if (overflow_o) begin
         cnt_d = '1;
      end else begin
         cnt_d = sum_s[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign cnt_next_o = cnt_d;

endmodule

// File: rtl/mchan_synch_table.sv
// ----------------------------------------------------------------------------
// mchan_synch_table
// Tracks outstanding TCDM-side and EXT-side command counts for NB_TRANS
// transfer IDs, producing per-ID busy status, one-cycle termination pulses
// and a sticky error report (first offending SID).
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   mchan_{tx,rx}_{req,gnt,sid,cmd_nb}_i : transfer registration
//   {tcdm,ext}_{tx,rx}_synch_{req,sid}_i : single-command releases
//   trans_registered_o                : an in-range registration was accepted
//   trans_status_o                    : per-ID busy (pending or terminating)
//   term_sig_o                        : per-ID one-cycle termination pulse
//   busy_o                            : any ID pending
//   err_o, err_sid_o, err_clr_i       : sticky error flag, its SID, clear
// ----------------------------------------------------------------------------
module mchan_synch_table
   import mchan_pkg::*;
#(
   parameter int NB_TRANS        = 4,
   parameter int TRANS_SID_WIDTH = sid_width(NB_TRANS),
   parameter int MCHAN_CMD_WIDTH = MCHAN_CMD_WIDTH_DEF,
   parameter int CNT_WIDTH       = MCHAN_CMD_WIDTH + 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       mchan_tx_req_i,
   input  logic                       mchan_tx_gnt_i,
   input  logic [TRANS_SID_WIDTH-1:0] mchan_tx_sid_i,
   input  logic [MCHAN_CMD_WIDTH-1:0] mchan_tx_cmd_nb_i,
   input  logic                       mchan_rx_req_i,
   input  logic                       mchan_rx_gnt_i,
   input  logic [TRANS_SID_WIDTH-1:0] mchan_rx_sid_i,
   input  logic [MCHAN_CMD_WIDTH-1:0] mchan_rx_cmd_nb_i,
   input  logic                       tcdm_tx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0] tcdm_tx_synch_sid_i,
   input  logic                       tcdm_rx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0] tcdm_rx_synch_sid_i,
   input  logic                       ext_tx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0] ext_tx_synch_sid_i,
   input  logic                       ext_rx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0] ext_rx_synch_sid_i,
   output logic                       trans_registered_o,
   output logic [NB_TRANS-1:0]        trans_status_o,
   output logic [NB_TRANS-1:0]        term_sig_o,
   output logic                       busy_o,
   output logic                       err_o,
   output logic [TRANS_SID_WIDTH-1:0] err_sid_o,
   input  logic                       err_clr_i
);

   // Event sources, listed in error-reporting priority order.
   localparam int NB_SRC = 6;

   logic [NB_SRC-1:0]          src_valid;
   logic [NB_SRC-1:0]          src_hit;
   logic [TRANS_SID_WIDTH-1:0] src_sid [NB_SRC];
   mchan_synch_err_e           src_err [NB_SRC];

   logic [NB_TRANS-1:0] tcdm_uf, tcdm_of, ext_uf, ext_of;
   logic [NB_TRANS-1:0] pending, pending_next, reg_hit;
   logic [NB_TRANS-1:0] term_q, term_d;

   logic                       err_q, err_d;
   logic [TRANS_SID_WIDTH-1:0] err_sid_q, err_sid_d;
   logic                       new_err;
   logic [TRANS_SID_WIDTH-1:0] new_sid;

   // A registration counts only when granted; releases have no grant.
   assign src_valid = {ext_rx_synch_req_i, ext_tx_synch_req_i,
                       tcdm_rx_synch_req_i, tcdm_tx_synch_req_i,
                       mchan_rx_req_i & mchan_rx_gnt_i,
                       mchan_tx_req_i & mchan_tx_gnt_i};
   assign src_sid   = '{mchan_tx_sid_i, mchan_rx_sid_i,
                        tcdm_tx_synch_sid_i, tcdm_rx_synch_sid_i,
                        ext_tx_synch_sid_i, ext_rx_synch_sid_i};

   generate
      for (genvar gi = 0; gi < NB_SRC; gi++) begin : g_src
         assign src_hit[gi] = src_valid[gi] && (int'(src_sid[gi]) < NB_TRANS);
      end
   endgenerate

   assign trans_registered_o = src_hit[0] | src_hit[1];

   generate
      for (genvar gi = 0; gi < NB_TRANS; gi++) begin : g_sid
         logic [NB_SRC-1:0]          sel;
         logic [MCHAN_CMD_WIDTH-1:0] add_tx, add_rx;
         logic [CNT_WIDTH-1:0]       tcdm_cnt, tcdm_nxt, ext_cnt, ext_nxt;

         always_comb begin
            for (int i = 0; i < NB_SRC; i++) begin
               sel[i] = src_hit[i] && (src_sid[i] == TRANS_SID_WIDTH'(gi));
            end
         end

         // A registration loads the same command count on both sides.
         assign add_tx = sel[0] ? mchan_tx_cmd_nb_i : '0;
         assign add_rx = sel[1] ? mchan_rx_cmd_nb_i : '0;

         mchan_synch_cnt #(
            .MCHAN_CMD_WIDTH(MCHAN_CMD_WIDTH),
            .CNT_WIDTH      (CNT_WIDTH)
         ) u_tcdm_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .add_a_i    (add_tx),
            .add_b_i    (add_rx),
            .dec_a_i    (sel[2]),
            .dec_b_i    (sel[3]),
            .cnt_o      (tcdm_cnt),
            .cnt_next_o (tcdm_nxt),
            .underflow_o(tcdm_uf[gi]),
            .overflow_o (tcdm_of[gi])
         );

         mchan_synch_cnt #(
            .MCHAN_CMD_WIDTH(MCHAN_CMD_WIDTH),
            .CNT_WIDTH      (CNT_WIDTH)
         ) u_ext_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .add_a_i    (add_tx),
            .add_b_i    (add_rx),
            .dec_a_i    (sel[4]),
            .dec_b_i    (sel[5]),
            .cnt_o      (ext_cnt),
            .cnt_next_o (ext_nxt),
            .underflow_o(ext_uf[gi]),
            .overflow_o (ext_of[gi])
         );

         assign pending[gi]      = (|tcdm_cnt) | (|ext_cnt);
         assign pending_next[gi] = (|tcdm_nxt) | (|ext_nxt);
         assign reg_hit[gi]      = sel[0] | sel[1];
         // reg_hit covers a transfer registered and drained in the same cycle.
         assign term_d[gi]       = !pending_next[gi] && (pending[gi] || reg_hit[gi]);
      end
   endgenerate

   // Classify each source: registrations can only overflow, releases can
   // only underflow the side they address.
   always_comb begin
      for (int i = 0; i < NB_SRC; i++) begin
         src_err[i] = NONE;
         if (src_valid[i] && !src_hit[i]) begin
            src_err[i] = BAD_SID;
         end else if (src_hit[i]) begin
            for (int s = 0; s < NB_TRANS; s++) begin
               if (src_sid[i] == TRANS_SID_WIDTH'(s)) begin
                  if (i < 2) begin
                     if (tcdm_of[s] || ext_of[s]) src_err[i] = OVERFLOW;
                  end else if (i < 4) begin
                     if (tcdm_uf[s]) src_err[i] = UNDERFLOW;
                  end else begin
                     if (ext_uf[s]) src_err[i] = UNDERFLOW;
                  end
               end
            end
         end
      end
   end

   // Lowest-index source wins: scan from the back so it is written last.
   always_comb begin
      new_err = 1'b0;
      new_sid = '0;
      for (int i = NB_SRC - 1; i >= 0; i--) begin
         if (src_err[i] != NONE) begin
            new_err = 1'b1;
            new_sid = src_sid[i];
         end
      end
   end

   // A clear in the same cycle as a new error lets the new error be captured.
   always_comb begin
      err_d     = err_q;
      err_sid_d = err_sid_q;
      if (new_err && (!err_q || err_clr_i)) begin
         err_d     = 1'b1;
         err_sid_d = new_sid;
      end else if (err_clr_i) begin
         err_d     = 1'b0;
         err_sid_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         term_q    <= '0;
         err_q     <= 1'b0;
         err_sid_q <= '0;
      end else begin
         term_q    <= term_d;
         err_q     <= err_d;
         err_sid_q <= err_sid_d;
      end
   end

   assign term_sig_o     = term_q;
   assign trans_status_o = pending | term_q;
   assign busy_o         = |pending;
   assign err_o          = err_q;
   assign err_sid_o      = err_sid_q;

endmodule

// File: tb/tb_mchan_synch_table.sv
// ----------------------------------------------------------------------------
// tb_mchan_synch_table
// Drives two table instances from the same stimulus: A with defaults
// (4 IDs, 12-bit counters) and B with 3 IDs and 10-bit counters, so SID 3
// is out of range for B and B saturates at 1023. A per-configuration
// reference model tracks counters as plain integers.
// ----------------------------------------------------------------------------
module tb_mchan_synch_table;
   import mchan_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, err_clr;
   logic       tx_req, tx_gnt, rx_req, rx_gnt;
   logic [1:0] tx_sid, rx_sid;
   logic [9:0] tx_cmd, rx_cmd;
   logic [3:0] s_req;          // tcdm_tx, tcdm_rx, ext_tx, ext_rx
   logic [1:0] s_sid [4];

   logic       a_reg, a_busy, a_err;
   logic [3:0] a_status, a_term;
   logic [1:0] a_esid;
   logic       b_reg, b_busy, b_err;
   logic [2:0] b_status, b_term;
   logic [1:0] b_esid;

   mchan_synch_table u_dut_a (
      .clk_i(clk), .rst_i(rst),
      .mchan_tx_req_i(tx_req), .mchan_tx_gnt_i(tx_gnt),
      .mchan_tx_sid_i(tx_sid), .mchan_tx_cmd_nb_i(tx_cmd),
      .mchan_rx_req_i(rx_req), .mchan_rx_gnt_i(rx_gnt),
      .mchan_rx_sid_i(rx_sid), .mchan_rx_cmd_nb_i(rx_cmd),
      .tcdm_tx_synch_req_i(s_req[0]), .tcdm_tx_synch_sid_i(s_sid[0]),
      .tcdm_rx_synch_req_i(s_req[1]), .tcdm_rx_synch_sid_i(s_sid[1]),
      .ext_tx_synch_req_i(s_req[2]),  .ext_tx_synch_sid_i(s_sid[2]),
      .ext_rx_synch_req_i(s_req[3]),  .ext_rx_synch_sid_i(s_sid[3]),
      .trans_registered_o(a_reg), .trans_status_o(a_status),
      .term_sig_o(a_term), .busy_o(a_busy),
      .err_o(a_err), .err_sid_o(a_esid), .err_clr_i(err_clr)
   );

   mchan_synch_table #(.NB_TRANS(3), .CNT_WIDTH(10)) u_dut_b (
      .clk_i(clk), .rst_i(rst),
      .mchan_tx_req_i(tx_req), .mchan_tx_gnt_i(tx_gnt),
      .mchan_tx_sid_i(tx_sid), .mchan_tx_cmd_nb_i(tx_cmd),
      .mchan_rx_req_i(rx_req), .mchan_rx_gnt_i(rx_gnt),
      .mchan_rx_sid_i(rx_sid), .mchan_rx_cmd_nb_i(rx_cmd),
      .tcdm_tx_synch_req_i(s_req[0]), .tcdm_tx_synch_sid_i(s_sid[0]),
      .tcdm_rx_synch_req_i(s_req[1]), .tcdm_rx_synch_sid_i(s_sid[1]),
      .ext_tx_synch_req_i(s_req[2]),  .ext_tx_synch_sid_i(s_sid[2]),
      .ext_rx_synch_req_i(s_req[3]),  .ext_rx_synch_sid_i(s_sid[3]),
      .trans_registered_o(b_reg), .trans_status_o(b_status),
      .term_sig_o(b_term), .busy_o(b_busy),
      .err_o(b_err), .err_sid_o(b_esid), .err_clr_i(err_clr)
   );

   // Reference model state, index [config][sid]
   int m_tc [2][4];
   int m_ex [2][4];
   bit m_term [2][4];
   bit m_err [2];
   int m_esid [2];

   int tests = 0;
   int fails = 0;
   int a_pulses [4];
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; err_clr = 1'b0;
      tx_req = 1'b0; tx_gnt = 1'b0; tx_sid = '0; tx_cmd = '0;
      rx_req = 1'b0; rx_gnt = 1'b0; rx_sid = '0; rx_cmd = '0;
      s_req = '0;
      for (int k = 0; k < 4; k++) s_sid[k] = '0;
   endtask

   // Apply current inputs for one cycle: predict, clock, compare.
   task automatic step();
      int  nb, cmax, t, e, sid;
      bit  v [6];
      int  sd [6];
      bit  hit [6];
      bit  tuf [4], tof [4], euf [4], eof [4];
      bit  pend_now, pend_nxt, rh, found, bad;
      int  ntc [2][4], nex [2][4];
      bit  nterm [2][4];
      string nm;
      logic [3:0] st, tm, got_st, got_tm;
      #1;
      for (int c = 0; c < 2; c++) begin
         nb   = (c == 0) ? 4 : 3;
         cmax = (c == 0) ? 4095 : 1023;
         nm   = (c == 0) ? "A" : "B";
         v[0] = tx_req && tx_gnt;  sd[0] = int'(tx_sid);
         v[1] = rx_req && rx_gnt;  sd[1] = int'(rx_sid);
         for (int k = 0; k < 4; k++) begin
            v[k+2] = s_req[k]; sd[k+2] = int'(s_sid[k]);
         end
         for (int i = 0; i < 6; i++) hit[i] = v[i] && (sd[i] < nb);
         check({nm, ".registered"}, (c == 0) ? a_reg : b_reg, hit[0] || hit[1]);
         for (int s = 0; s < 4; s++) begin
            t = m_tc[c][s]; e = m_ex[c][s]; rh = 1'b0;
            if (hit[0] && sd[0] == s) begin t += int'(tx_cmd); e += int'(tx_cmd); rh = 1'b1; end
            if (hit[1] && sd[1] == s) begin t += int'(rx_cmd); e += int'(rx_cmd); rh = 1'b1; end
            if (hit[2] && sd[2] == s) t--;
            if (hit[3] && sd[3] == s) t--;
            if (hit[4] && sd[4] == s) e--;
            if (hit[5] && sd[5] == s) e--;
            tuf[s] = t < 0; tof[s] = t > cmax; euf[s] = e < 0; eof[s] = e > cmax;
            if (t < 0) t = 0; if (t > cmax) t = cmax;
            if (e < 0) e = 0; if (e > cmax) e = cmax;
            pend_now = (m_tc[c][s] != 0) || (m_ex[c][s] != 0);
            pend_nxt = (t != 0) || (e != 0);
            ntc[c][s] = t; nex[c][s] = e;
            nterm[c][s] = !pend_nxt && (pend_now || rh);
         end
         // First source in priority order that is in error.
         found = 1'b0; sid = 0;
         for (int i = 0; i < 6; i++) begin
            if (!found) begin
               bad = v[i] && (sd[i] >= nb);
               if (!bad && hit[i]) begin
                  if (i < 2)      bad = tof[sd[i]] || eof[sd[i]];
                  else if (i < 4) bad = tuf[sd[i]];
                  else            bad = euf[sd[i]];
               end
               if (bad) begin found = 1'b1; sid = sd[i]; end
            end
         end
         if (rst) begin
            for (int s = 0; s < 4; s++) begin ntc[c][s] = 0; nex[c][s] = 0; nterm[c][s] = 0; end
            m_err[c] = 0; m_esid[c] = 0;
         end else if (found && (!m_err[c] || err_clr)) begin
            m_err[c] = 1; m_esid[c] = sid;
         end else if (err_clr) begin
            m_err[c] = 0; m_esid[c] = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < 2; c++) begin
         nb = (c == 0) ? 4 : 3;
         nm = (c == 0) ? "A" : "B";
         st = '0; tm = '0;
         for (int s = 0; s < 4; s++) begin
            m_tc[c][s] = ntc[c][s]; m_ex[c][s] = nex[c][s]; m_term[c][s] = nterm[c][s];
            if (s < nb) begin
               tm[s] = m_term[c][s];
               st[s] = (m_tc[c][s] != 0) || (m_ex[c][s] != 0) || m_term[c][s];
            end
         end
         got_st = (c == 0) ? a_status : {1'b0, b_status};
         got_tm = (c == 0) ? a_term   : {1'b0, b_term};
         check({nm, ".status"}, got_st, st);
         check({nm, ".term"}, got_tm, tm);
         check({nm, ".busy"}, (c == 0) ? a_busy : b_busy, |(st & ~tm));
         check({nm, ".err"}, (c == 0) ? a_err : b_err, m_err[c]);
         check({nm, ".err_sid"}, (c == 0) ? a_esid : b_esid, m_esid[c]);
      end
      for (int s = 0; s < 4; s++) if (a_term[s]) a_pulses[s]++;
   endtask

   task automatic do_reset();
      idle(); rst = 1'b1; step(); rst = 1'b0; step();
      for (int s = 0; s < 4; s++) a_pulses[s] = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      do_reset();
      check("reset.status", a_status, 4'h0);
      check("reset.err", a_err, 1'b0);

      // Single transfer on sid 2 drained one release per cycle
      tx_req = 1; tx_gnt = 1; tx_sid = 2; tx_cmd = 3; step(); idle();
      check("s2.status_after_reg", a_status, 4'b0100);
      for (int k = 0; k < 3; k++) begin s_req[0] = 1; s_sid[0] = 2; step(); idle(); end
      for (int k = 0; k < 3; k++) begin s_req[3] = 1; s_sid[3] = 2; step(); idle(); end
      step(); step();
      check("s2.pulses", a_pulses[2], 1);
      check("s2.other_pulses", a_pulses[0] + a_pulses[1] + a_pulses[3], 0);

      // Same-cycle register + release on sid0, register sid1
      do_reset();
      tx_req = 1; tx_gnt = 1; tx_sid = 0; tx_cmd = 1;
      rx_req = 1; rx_gnt = 1; rx_sid = 1; rx_cmd = 2;
      s_req = 4'b0101; s_sid[0] = 0; s_sid[2] = 0;
      step(); idle();
      check("same.term0", a_term[0], 1'b1);
      for (int k = 0; k < 2; k++) begin s_req = 4'b0101; s_sid[0] = 1; s_sid[2] = 1; step(); idle(); end
      step();

      // Four releases plus a registration of 4 on sid3, then drain 2/2
      do_reset();
      tx_req = 1; tx_gnt = 1; tx_sid = 3; tx_cmd = 4; s_req = 4'hF;
      for (int k = 0; k < 4; k++) s_sid[k] = 3;
      step(); idle();
      for (int k = 0; k < 2; k++) begin s_req = 4'hF; for (int j = 0; j < 4; j++) s_sid[j] = 3; step(); idle(); end
      step();
      check("sid3.pulses", a_pulses[3], 1);

      // Release on idle sid1: underflow error, then clear
      do_reset();
      s_req[0] = 1; s_sid[0] = 1; step(); idle();
      check("uf.err", a_err, 1'b1);
      check("uf.err_sid", a_esid, 2'd1);
      check("uf.no_term", a_term, 4'h0);
      err_clr = 1; step(); idle();
      check("uf.cleared", a_err, 1'b0);

      // Out-of-range SID on B, then overflow on B
      do_reset();
      tx_req = 1; tx_gnt = 1; tx_sid = 3; tx_cmd = 1; step(); idle();
      check("bad.b_err", b_err, 1'b1);
      check("bad.b_sid", b_esid, 2'd3);
      do_reset();
      for (int k = 0; k < 3; k++) begin tx_req = 1; tx_gnt = 1; tx_sid = 0; tx_cmd = 10'd1023; step(); end
      idle(); step();
      check("ovf.b_err", b_err, 1'b1);
      check("ovf.a_err", a_err, 1'b0);

      // Reset mid-transfer
      do_reset();
      tx_req = 1; tx_gnt = 1; tx_sid = 0; tx_cmd = 5; step(); idle();
      rst = 1; step(); rst = 0;
      check("rst.status", a_status, 4'h0);
      check("rst.term", a_term, 4'h0);
      step();
      check("rst.no_pulse", a_pulses[0], 0);

      // Randomized traffic
      for (int n = 0; n < 2500; n++) begin
         rst     = ($urandom_range(0, 149) == 0);
         err_clr = ($urandom_range(0, 15) == 0);
         tx_req  = ($urandom_range(0, 2) == 0);
         tx_gnt  = ($urandom_range(0, 3) != 0);
         tx_sid  = 2'($urandom_range(0, 3));
         tx_cmd  = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 4));
         rx_req  = ($urandom_range(0, 2) == 0);
         rx_gnt  = ($urandom_range(0, 3) != 0);
         rx_sid  = 2'($urandom_range(0, 3));
         rx_cmd  = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 4));
         for (int k = 0; k < 4; k++) begin
            s_req[k] = ($urandom_range(0, 1) == 0);
            s_sid[k] = 2'($urandom_range(0, 3));
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
